// File: rtl/instr_fetch_pkg.sv
// Shared fetch-side definitions: reset PC, NOP encoding, queue entry layout.
// Imported by instr_fetch and fetch_fifo.
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries; flush empties it in one cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited sequential requests, prefetch queue, and
// redirect handling that flushes the queue and drops stale in-flight responses.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int          CW       = $clog2(DEPTH);
    localparam logic [31:0] START_PC = align_pc(RESET_PC);

    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [31:0]  target_pc;
    logic [CW:0]  outstanding;
    logic [CW:0]  next_outstanding;
    logic [CW:0]  drop_cnt;
    logic [CW:0]  count;
    logic [CW+1:0] credit_used;
    logic         full;
    logic         empty;
    logic         req_fire;
    logic         rsp_keep;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    // Conservative credit: a same-cycle pop does not free a slot.
    assign credit_used    = (CW+2)'(count) + (CW+2)'(outstanding);
    assign imem_req_valid = !rst && (credit_used < (CW+2)'(DEPTH));
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop            = ir_valid && ir_ready;
    assign target_pc      = align_pc(redirect_pc);

    assign push_entry.pc    = rsp_pc;
    assign push_entry.instr = imem_rsp_data;

    assign ir_valid = !empty;
    assign IR       = empty ? NOP_INSTR : head.instr;
    assign ir_pc    = empty ? 32'h0     : head.pc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_outstanding = outstanding;
        if (req_fire)       next_outstanding = next_outstanding + (CW+1)'(1);
        if (imem_rsp_valid) next_outstanding = next_outstanding - (CW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= START_PC;
            rsp_pc      <= START_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= next_outstanding;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= next_outstanding;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - (CW+1)'(1);
                    else                rsp_pc   <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(full && rsp_keep && !pop));

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that produces the 32-bit `IR` word consumed by the `controller` decoder. It holds the fetch PC and issues sequential word requests to instruction memory. Responses are buffered in a small prefetch queue, and each word is presented downstream with its PC over a valid/ready handshake. A redirect from the branch/jump resolution stage flushes the queue and discards any stale in-flight responses.

## Interface

Parameters:

- `DEPTH`, 4: prefetch queue entries; also the maximum number of outstanding memory requests. Must be a power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req_valid` output 1: request pending.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_addr` output 32: word address of the request; bits [1:0] always 0.
- `imem_rsp_valid` input 1: response data valid. Responses arrive in request order, ≥1 cycle after acceptance, and cannot be stalled.
- `imem_rsp_data` input 32: instruction word.
- `ir_valid` output 1: `IR` / `ir_pc` hold a valid instruction.
- `ir_ready` input 1: decoder consumes the instruction this cycle.
- `IR` output 32: instruction word to the decoder.
- `ir_pc` output 32: address of `IR`.
- `redirect_valid` input 1: taken branch/jump; restart fetch.
- `redirect_pc` input 32: new fetch address; bits [1:0] are ignored and forced to 0.

## Operation

- **State:** `fetch_pc` (next request address), `rsp_pc` (PC tagged onto the next accepted response), `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), and the queue of {pc, instr} entries with occupancy `count`.
- **Issue rule:** `imem_req_valid = !rst_state && (count + outstanding < DEPTH)`. The rule is conservative: a same-cycle pop does not free credit. Because of this credit, the queue never overflows and responses never need backpressure.
- **Accepted request** (`imem_req_valid && imem_req_ready`): `fetch_pc += 4` and `outstanding += 1`.
- **Response handling:** every response decrements `outstanding`.
  - If `drop_cnt > 0`, the response is discarded and `drop_cnt` decrements.
  - Otherwise {`rsp_pc`, `imem_rsp_data`} is pushed and `rsp_pc += 4`.
- **Pop:** occurs when `ir_valid && ir_ready`. The head of the queue drives `IR` / `ir_pc`, and `ir_valid = (count != 0)`.
- **Redirect** (priority over everything else in the same cycle). At the closing edge:
  - `count` is set to 0.
  - `fetch_pc` and `rsp_pc` are set to `redirect_pc & ~3`.
  - `drop_cnt` is set to outstanding-after-this-cycle: existing outstanding, plus a request accepted this cycle, minus a response arriving this cycle (the response arriving in the redirect cycle is itself discarded).
  - A handshake completing in the redirect cycle still counts as consumed.
- **Wrap-around:** `fetch_pc` and `rsp_pc` wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- **Queue:** pointers wrap modulo DEPTH. Simultaneous push and pop when full or empty is legal; `count` is unchanged by a push+pop pair.
- No delay-slot or exception handling; the redirect source owns those decisions.

## Timing

- **Reset values:**
  - `imem_req_valid` = 0, `imem_addr` = RESET_PC.
  - `ir_valid` = 0, `IR` = 32'h0, `ir_pc` = 32'h0.
  - `outstanding`, `drop_cnt`, `count` = 0.
- **After reset:** the first request is asserted in the first cycle after `rst` deasserts.
- **Latency:** a response arriving in cycle N is visible on `ir_valid` / `IR` in cycle N+1 when the queue was empty. There is no combinational path from `imem_rsp_*` to `IR`.
- **Redirect in cycle N:**
  - `ir_valid` = 0 in N+1, unless a new-stream response is impossible before then, which holds by construction.
  - `imem_addr` = redirect target in N+1 if credit allows.
- **Request holding:** `imem_req_valid` and `imem_addr` stay stable until accepted, except on redirect, which may retarget a pending un-accepted request.
- **Reset mid-operation:** state clears asynchronously. Responses that arrive after reset for pre-reset requests are not tracked; the memory side must also be reset.

## Structure

- `RESET_PC` default and the NOP encoding 32'h0000_0000 belong in the shared CPU defines header next to the opcode parameters.
- One sub-module: `fetch_fifo`, a synchronous FIFO of width 64 and depth `DEPTH`, with a `flush` input and `count`, `full` and `empty` outputs.
- Credit and drop counters live in `instr_fetch`.

## Test plan

- **Reset and stream:** hold `imem_req_ready` = 1 with a 1-cycle response model and `ir_ready` = 1. Required: `ir_pc` sequence 0x0, 0x4, 0x8, … with matching `IR`, and first `ir_valid` 3 cycles after reset release.
- **Backpressure:** `ir_ready` = 0 for 20 cycles. Required: exactly 4 requests issued (DEPTH = 4), `imem_req_valid` then low, `IR` held stable at PC 0x0.
- **Redirect with 3 outstanding** (memory latency 4): `redirect_pc` = 0x100. Required: the 3 stale responses are dropped, the next `ir_valid` shows `ir_pc` = 0x100, and no 0x0C/0x10 words appear.
- **Redirect coincident with a response and a pop:** redirect to 0x2002. Required: both in-cycle items are discarded, the new stream starts at 0x2000, and the popped instruction counts as consumed once.
- **Wrap:** redirect to 0xFFFF_FFF8. Required: `ir_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-stream:** assert `rst` between clock edges. Required: `ir_valid` and `imem_req_valid` drop immediately (before the next edge), and fetching restarts at `RESET_PC`.
